// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    WRITE,
    CHECK,
    DONE,
    ERROR
  } state_e;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

  typedef logic [15:0] length_t;

endpackage

// File: rtl/imem_word_assembler.sv
// Collects four stream bytes into one little-endian 32-bit instruction word.
module imem_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clr_i,
  input  logic        byte_vld_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_full_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  // Shifting in from the top leaves the first byte of a word in bits [7:0].
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clr_i) begin
      cnt_d  = '0;
      word_d = '0;
    end else if (byte_vld_i) begin
      cnt_d  = cnt_q + 2'd1;
      word_d = {byte_i, word_q[31:8]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_o      = word_q;
  assign word_full_o = byte_vld_i && (cnt_q == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_program_loader.sv
// Boot loader: streams a length-prefixed program into instruction memory, then
// releases the processor. Define IMEM_LOADER_CHECKSUM_EN to add the XOR trailer check.
module imem_program_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 256
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Start,
  input  logic [7:0]        Rx_Data,
  input  logic              Rx_Valid,
  output logic              Rx_Ready,
  output logic              Imem_We,
  output logic [ADDR_W-1:0] Imem_Addr,
  output logic [31:0]       Imem_WData,
  output logic              Proc_Reset,
  output logic              Done,
  output logic              Error
);

  localparam length_t MAX_LEN = length_t'(MAX_WORDS);

  state_e            state_q, state_d;
  logic [7:0]        len_lo_q, len_lo_d;
  length_t           left_q, left_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic    accept;
  logic    start_ok;
  logic    word_full;
  length_t len_rx;

  assign Rx_Ready = (state_q == LEN_LO) || (state_q == LEN_HI) ||
                    (state_q == DATA)   || (state_q == CHECK);
  assign accept   = Rx_Valid && Rx_Ready;
  assign start_ok = Start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERROR));
  assign len_rx   = {Rx_Data, len_lo_q};

  imem_word_assembler u_asm (
    .clk_i      (Clk),
    .rst_ni     (Reset_n),
    .clr_i      (start_ok),
    .byte_vld_i (accept && (state_q == DATA)),
    .byte_i     (Rx_Data),
    .word_o     (Imem_WData),
    .word_full_o(word_full)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  // Only payload bytes contribute; the length prefix is excluded.
  always_comb begin
    csum_d = csum_q;
    if (start_ok) begin
      csum_d = '0;
    end else if (accept && (state_q == DATA)) begin
      csum_d = csum_q ^ Rx_Data;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    left_d   = left_q;
    addr_d   = addr_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (Start) begin
          state_d = LEN_LO;
          addr_d  = '0;
        end
      end
      LEN_LO: begin
        if (accept) begin
          len_lo_d = Rx_Data;
          state_d  = LEN_HI;
        end
      end
      LEN_HI: begin
        if (accept) begin
          left_d = len_rx;
          if (len_rx > MAX_LEN) begin
            state_d = ERROR;
          end else if (len_rx == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHECK;
`else
            state_d = DONE;
`endif
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (word_full) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        addr_d = addr_q + ADDR_W'(1);
        left_d = left_q - 16'd1;
        if (left_q != 16'd1) begin
          state_d = DATA;
        end else begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          if (Rx_Data == csum_q) begin
            state_d = DONE;
          end else begin
            state_d = ERROR;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      len_lo_q <= '0;
      left_q   <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      left_q   <= left_d;
      addr_q   <= addr_d;
    end
  end

  assign Imem_We    = (state_q == WRITE);
  assign Imem_Addr  = addr_q;
  assign Proc_Reset = (state_q != DONE);
  assign Done       = (state_q == DONE);
  assign Error      = (state_q == ERROR);

endmodule

// File: tb/tb_imem_program_loader.sv
// Table-driven bench for imem_program_loader with a write scoreboard.
module tb_imem_program_loader;

  localparam int ADDR_W = 8;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic              Start = 1'b0;
  logic [7:0]        Rx_Data = 8'h00;
  logic              Rx_Valid = 1'b0;
  logic              Rx_Ready;
  logic              Imem_We;
  logic [ADDR_W-1:0] Imem_Addr;
  logic [31:0]       Imem_WData;
  logic              Proc_Reset;
  logic              Done;
  logic              Error;

  always #5 Clk = ~Clk;

  imem_program_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(256)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .Start     (Start),
    .Rx_Data   (Rx_Data),
    .Rx_Valid  (Rx_Valid),
    .Rx_Ready  (Rx_Ready),
    .Imem_We   (Imem_We),
    .Imem_Addr (Imem_Addr),
    .Imem_WData(Imem_WData),
    .Proc_Reset(Proc_Reset),
    .Done      (Done),
    .Error     (Error)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  // Stream bytes are left-aligned: byte i sits at bits [95-8i -: 8].
  typedef struct {
    logic [95:0] bytes;
    int          nbytes;
    bit          gaps;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vt[5];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  always @(negedge Clk) begin : monitor
    wr_t e;
    if (Reset_n && Imem_We) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_write: got addr %h data %h, expected no write", Imem_Addr, Imem_WData);
      end else begin
        e = exp_q.pop_front();
        chk("write_addr", 32'(Imem_Addr), 32'(e.addr));
        chk("write_data", Imem_WData, e.data);
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      Rx_Valid = 1'b0;
      @(negedge Clk);
    end
    Rx_Valid = 1'b1;
    Rx_Data  = b;
    n = 0;
    while (!Rx_Ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (n >= 50) begin
      n_total++;
      $display("FAIL rx_ready_timeout: got Rx_Ready=0 for 50 cycles, expected 1");
    end
    @(negedge Clk);
  endtask

  task automatic start_pulse();
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("start_ready", 32'(Rx_Ready), 32'd1);
    chk("start_err",   32'(Error), 32'd0);
    chk("start_done",  32'(Done), 32'd0);
    chk("start_prst",  32'(Proc_Reset), 32'd1);
  endtask

  task automatic run_bytes(input int idx, input int limit, output int nwords);
    logic [95:0] bs;
    logic [7:0]  b;
    logic [31:0] acc;
    int          n, k;
    bs  = vt[idx].bytes;
    n   = int'({bs[87:80], bs[95:88]});
    acc = '0;
    nwords = (n <= 256) ? n : 0;
    start_pulse();
    for (int i = 0; i < limit; i++) begin
      b = bs[95-8*i -: 8];
      k = i - 2;
      if (k >= 0 && k < 4 * n) begin
        acc[8*(k%4) +: 8] = b;
        if (k % 4 == 3) exp_q.push_back('{addr: ADDR_W'(k / 4), data: acc});
      end
      send(b, vt[idx].gaps);
    end
  endtask

  task automatic run_vector(input int idx);
    int nw;
    run_bytes(idx, vt[idx].nbytes, nw);
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("done_timing", 32'(Done), 32'(vt[idx].exp_done));
`else
    chk("done_timing", 32'(Done), 32'(vt[idx].exp_done && nw == 0));
`endif
    chk("err_timing", 32'(Error), 32'(vt[idx].exp_err));
    Rx_Valid = 1'b0;
    repeat (2) @(negedge Clk);
    chk("final_done",  32'(Done), 32'(vt[idx].exp_done));
    chk("final_err",   32'(Error), 32'(vt[idx].exp_err));
    chk("final_prst",  32'(Proc_Reset), 32'(!vt[idx].exp_done));
    chk("final_ready", 32'(Rx_Ready), 32'd0);
    chk("all_writes",  32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500us, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;
`ifdef IMEM_LOADER_CHECKSUM_EN
    vt[0] = '{96'h0200_0500_0820_2050_0901_5500, 11, 1'b0, 1'b1, 1'b0};
    vt[1] = '{96'h0200_0500_0820_2050_0901_5400, 11, 1'b0, 1'b0, 1'b1};
    vt[2] = '{96'h0000_0000_0000_0000_0000_0000,  3, 1'b0, 1'b1, 1'b0};
    vt[3] = '{96'h0200_0500_0820_2050_0901_5500, 11, 1'b1, 1'b1, 1'b0};
    vt[4] = '{96'h0101_0000_0000_0000_0000_0000,  2, 1'b0, 1'b0, 1'b1};
`else
    vt[0] = '{96'h0200_0500_0820_2050_0901_0000, 10, 1'b0, 1'b1, 1'b0};
    vt[1] = '{96'h0100_7856_3412_0000_0000_0000,  6, 1'b0, 1'b1, 1'b0};
    vt[2] = '{96'h0000_0000_0000_0000_0000_0000,  2, 1'b0, 1'b1, 1'b0};
    vt[3] = '{96'h0200_0500_0820_2050_0901_0000, 10, 1'b1, 1'b1, 1'b0};
    vt[4] = '{96'h0101_0000_0000_0000_0000_0000,  2, 1'b0, 1'b0, 1'b1};
`endif

    repeat (2) @(negedge Clk);
    chk("rst_ready", 32'(Rx_Ready), 32'd0);
    chk("rst_we",    32'(Imem_We), 32'd0);
    chk("rst_addr",  32'(Imem_Addr), 32'd0);
    chk("rst_wdata", Imem_WData, 32'd0);
    chk("rst_prst",  32'(Proc_Reset), 32'd1);
    chk("rst_done",  32'(Done), 32'd0);
    chk("rst_err",   32'(Error), 32'd0);
    Reset_n  = 1'b1;
    Rx_Valid = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      chk("idle_no_ready", 32'(Rx_Ready), 32'd0);
    end
    Rx_Valid = 1'b0;
    @(negedge Clk);

    for (int v = 0; v < 5; v++) run_vector(v);

    // Drop reset after the first word has been written, then reload.
    run_bytes(0, 6, nw);
    Rx_Valid = 1'b0;
    #2 Reset_n = 1'b0;
    @(negedge Clk);
    chk("midrst_prst",  32'(Proc_Reset), 32'd1);
    chk("midrst_addr",  32'(Imem_Addr), 32'd0);
    chk("midrst_ready", 32'(Rx_Ready), 32'd0);
    chk("midrst_done",  32'(Done), 32'd0);
    chk("midrst_we",    32'(Imem_We), 32'd0);
    chk("midrst_word0", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    Reset_n = 1'b1;
    @(negedge Clk);
    run_vector(0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/imem_program_loader.md
# imem_program_loader

Boot-time loader that sits directly upstream of the single-cycle processor and its instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes those words to consecutive instruction-memory addresses from 0, then releases the processor's active-high reset. While loading, the processor is held in reset, so the processor core needs no changes.

## Interface
- ADDR_W, default 8: instruction-memory word-address width.
- MAX_WORDS, default 256: largest accepted program length in words. Must satisfy MAX_WORDS ≤ 2^ADDR_W.
- Clk  in  1  system clock; everything is on the rising edge.
- Reset_n  in  1  reset, asynchronous and active-low.
- Start  in  1  one-cycle request to begin a load. Honoured only in IDLE, DONE or ERROR.
- Rx_Data  in  8  stream byte.
- Rx_Valid  in  1  Rx_Data is valid.
- Rx_Ready  out  1  loader can accept a byte.
- Imem_We  out  1  instruction-memory write strobe, one cycle per word.
- Imem_Addr  out  ADDR_W  word address being written.
- Imem_WData  out  32  assembled instruction word.
- Proc_Reset  out  1  active-high reset driven to the processor.
- Done  out  1  program loaded and processor released.
- Error  out  1  load aborted.

## Operation
- Stream format: a 16-bit word count N (low byte first), then N×4 data bytes (each word little-endian), then one checksum byte if checksum is enabled.
- A byte transfers on a rising edge when Rx_Valid and Rx_Ready are both high. Rx_Valid may drop at any time, and any gap length is tolerated.
- States and transitions:
  - IDLE: on Start, go to LEN_LO.
  - LEN_LO: accept a byte, go to LEN_HI.
  - LEN_HI: accept a byte. If N > MAX_WORDS, go to ERROR. If N = 0, go to CHECK (checksum enabled) or DONE (disabled). Otherwise go to DATA.
  - DATA: accept 4 bytes, then go to WRITE.
  - WRITE: one cycle. Then go to DATA if words remain, else CHECK or DONE.
  - CHECK: accept 1 byte. Match goes to DONE, mismatch goes to ERROR.
  - DONE and ERROR: hold until Start, which goes to LEN_LO.
- Rx_Ready is high only in LEN_LO, LEN_HI, DATA and CHECK.
- Byte assembly: byte k of a word goes to Imem_WData[8k+7:8k].
- Imem_Addr starts at 0 for each load and increments by 1 after each WRITE. It stays within range because N ≤ MAX_WORDS.
- Proc_Reset is 1 in every state except DONE. Leaving DONE on Start reasserts it in the next cycle.
- Error is 1 only in ERROR. Words already written are not rolled back.
- Start is ignored in LEN_LO, LEN_HI, DATA, WRITE and CHECK.
- Reset_n low, from any state including mid-load: immediately enter IDLE and clear the word and byte counters.
- Reset values: Rx_Ready 0, Imem_We 0, Imem_Addr 0, Imem_WData 0, Proc_Reset 1, Done 0, Error 0.

## Timing
- Imem_We is high in the cycle after the 4th byte of a word is accepted. Imem_Addr and Imem_WData are stable in that same cycle.
- Rx_Ready is low during WRITE, so the best case is 5 cycles per word.
- Done rises, and Proc_Reset falls, in the cycle after the final WRITE (checksum disabled) or after the checksum byte is accepted.
- Error rises in the cycle after the offending byte is accepted.
- Minimum latency from Start to the first Rx_Ready is 1 cycle.

## Configuration
- The macro IMEM_LOADER_CHECKSUM_EN compiles the checksum feature in or out.
- Defined: a running XOR covers all N×4 data bytes (not the length bytes). The CHECK state compares the trailing byte against it, and the XOR is cleared on Start.
- Undefined: the CHECK state and the XOR register are absent. No trailing byte is expected, and a mismatch can never set Error.

## Structure
- Package imem_loader_pkg holds:
  - the state enum (IDLE, LEN_LO, LEN_HI, DATA, WRITE, CHECK, DONE, ERROR);
  - LEN_BYTES = 2 and WORD_BYTES = 4;
  - the 16-bit length type.
- Sub-module imem_word_assembler: an 8-to-32 shift register with a 2-bit byte counter, a word_full flag and a clear input. The top level holds the FSM, word counter, address and checksum.

## Test plan
- Reset: hold Reset_n low for 2 cycles -> all outputs at their reset values, with Proc_Reset = 1. Then drive Rx_Valid high -> Rx_Ready stays 0 until Start.
- Normal load (checksum enabled): Start, then bytes 02 00 05 00 08 20 20 50 09 01 55 -> two writes: addr 0 = 0x20080005 and addr 1 = 0x01095020. Then Done = 1, Proc_Reset = 0, Error = 0.
- Bad checksum: same stream with final byte 0x54 -> both words still written, Error = 1, Proc_Reset stays 1. A new Start clears Error.
- Oversize: length bytes 01 01 (N = 257, MAX_WORDS = 256) -> Error the cycle after the second byte, with no Imem_We pulse.
- Empty program and gaps: length 00 00 then checksum 00 -> Done with no writes. Repeat the normal load with Rx_Valid toggling every cycle -> identical writes.
- Reset mid-load: drop Reset_n after the 6th byte -> IDLE, Proc_Reset = 1, Imem_Addr = 0. A full reload after Start then succeeds.
